nested_object_fifo: RTL and testbench

- Parametrised successor to the serializer-facing object buffer.
- Holds TABLE_ENTRY descriptors in a circular FIFO and presents them in order to the serializers over a valid/ready handshake.
- Tracks the C++ object base address through nested sub-messages with a bounded pointer stack.
- Consumes end-of-object markers (field_id == 0) internally, signals message completion, and flags stack overflow instead of silently wrapping.

---
 rtl/nested_object_fifo.sv | 147 ++++++++++++++
 tb/tb_nested_object_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_object_fifo.sv
// Circular FIFO of table descriptors feeding the serializers, with a bounded
// base-address stack that follows nested sub-messages and consumes end markers.
module nested_object_fifo #(
  parameter int DEPTH = 64,
  parameter int STACK_DEPTH = 16,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] ROOT_ADDR = 'h100,
  parameter int FIELD_W = 8,
  localparam int ENTRY_W = ADDR_W + 1 + FIELD_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int DEP_W = $clog2(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  root_addr,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] in_entry,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ENTRY_W-1:0] out_entry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_base_addr,
  output logic [CNT_W-1:0]   count,
  output logic [DEP_W-1:0]   depth,
  output logic               done,
  output logic               err_overflow,
  output logic [1:0]         fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  offset;
    logic               nested;
    logic [FIELD_W-1:0] field_id;
  } table_entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t             state_q, state_d;
  table_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [DEP_W-1:0]   depth_q, depth_d, depth_inc;
  logic               done_q, done_d, err_q, err_d, push_stack;
  logic [ADDR_W-1:0]  push_addr;
  table_entry_t       head_entry;
  logic               empty, is_marker, deq_data, marker_pop, pop, push;

  // Handshake: a transfer happens on a cycle where valid && ready are both high
  // at the rising clock edge; valid never depends on ready on either side.
  assign head_entry = mem[head_q];
  assign empty      = (count_q == '0);
  assign is_marker  = (head_entry.field_id == '0);
  assign in_ready   = (count_q < CNT_W'(DEPTH));
  assign out_valid  = (state_q == RUN) && !empty && !is_marker;
  assign deq_data   = out_valid && out_ready;
  assign marker_pop = (state_q == RUN) && !empty && is_marker;
  assign pop        = deq_data || marker_pop;
  assign push       = in_valid && in_ready && !flush;
  assign depth_inc  = depth_q + DEP_W'(1);
  assign push_addr  = stack_q[depth_q] + head_entry.offset;

  assign out_entry     = head_entry;
  assign out_base_addr = stack_q[depth_q];
  assign count         = count_q;
  assign depth         = depth_q;
  assign done          = done_q;
  assign err_overflow  = err_q;
  assign fsm_state     = state_q;

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= table_entry_t'(in_entry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // start overrides any stack effect of a handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    done_d     = done_q;
    err_d      = err_q;
    push_stack = 1'b0;
    if (start) begin
      state_d = RUN;
      depth_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (deq_data && head_entry.nested) begin
        if (depth_q == DEP_W'(STACK_DEPTH - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          depth_d    = depth_inc;
          push_stack = 1'b1;
        end
      end
      if (marker_pop) begin
        if (depth_q != '0) begin
          depth_d = depth_q - DEP_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      stack_q[0] <= ROOT_ADDR;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (start)           stack_q[0] <= root_addr;
      else if (push_stack) stack_q[depth_inc] <= push_addr;
    end
  end

endmodule

// File: tb/tb_nested_object_fifo.sv
// Directed bench: instance a (DEPTH=4, STACK_DEPTH=2) covers backpressure/wrap
// and overflow; instance b (DEPTH=8, STACK_DEPTH=4) covers messages, flush, reset.
module tb_nested_object_fifo;
  localparam int ENTRY_W = 73;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, flush, in_valid, out_ready;
  logic [63:0]        root_addr;
  logic [ENTRY_W-1:0] in_entry;

  logic               a_in_ready, a_out_valid, a_done, a_err;
  logic [ENTRY_W-1:0] a_out_entry;
  logic [63:0]        a_base;
  logic [2:0]         a_count;
  logic [0:0]         a_depth;
  logic [1:0]         a_state;

  logic               b_in_ready, b_out_valid, b_done, b_err;
  logic [ENTRY_W-1:0] b_out_entry;
  logic [63:0]        b_base;
  logic [3:0]         b_count;
  logic [1:0]         b_depth;
  logic [1:0]         b_state;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  nested_object_fifo #(.DEPTH(4), .STACK_DEPTH(2)) u_a (
    .clk(clk), .reset(reset), .start(start), .root_addr(root_addr), .flush(flush),
    .in_entry(in_entry), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_entry(a_out_entry), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_base_addr(a_base), .count(a_count), .depth(a_depth), .done(a_done),
    .err_overflow(a_err), .fsm_state(a_state)
  );

  nested_object_fifo #(.DEPTH(8), .STACK_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .start(start), .root_addr(root_addr), .flush(flush),
    .in_entry(in_entry), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_entry(b_out_entry), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_base_addr(b_base), .count(b_count), .depth(b_depth), .done(b_done),
    .err_overflow(b_err), .fsm_state(b_state)
  );

  function automatic logic [ENTRY_W-1:0] mk(input logic [7:0] id, input logic nst,
                                            input logic [63:0] off);
    return {off, nst, id};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [ENTRY_W-1:0] e);
    in_entry = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic [63:0] addr);
    root_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    root_addr = '0; in_entry = '0;
    #12;
    do_reset();

    // 1: flat message
    chk("rst_count", 64'(b_count), 0);
    chk("rst_valid", 64'(b_out_valid), 0);
    chk("rst_in_ready", 64'(b_in_ready), 1);
    chk("rst_base", b_base, 64'h100);
    chk("rst_done", 64'(b_done), 0);
    chk("rst_err", 64'(b_err), 0);
    chk("rst_state", 64'(b_state), 0);
    enq(mk(1, 0, 0)); enq(mk(2, 0, 0)); enq(mk(0, 0, 0));
    chk("t1_idle_valid", 64'(b_out_valid), 0);
    chk("t1_count3", 64'(b_count), 3);
    out_ready = 1'b1;
    pulse_start(64'h1000);
    chk("t1_v1", 64'(b_out_valid), 1);
    chk("t1_id1", 64'(b_out_entry[7:0]), 1);
    chk("t1_base1", b_base, 64'h1000);
    tick();
    chk("t1_id2", 64'(b_out_entry[7:0]), 2);
    chk("t1_base2", b_base, 64'h1000);
    tick();
    chk("t1_marker_valid", 64'(b_out_valid), 0);
    chk("t1_marker_done", 64'(b_done), 0);
    tick();
    chk("t1_done", 64'(b_done), 1);
    chk("t1_count0", 64'(b_count), 0);
    chk("t1_state", 64'(b_state), 2);
    out_ready = 1'b0;

    // 2: nested message
    do_reset();
    enq(mk(3, 1, 64'h40)); enq(mk(1, 0, 0)); enq(mk(0, 0, 0));
    enq(mk(4, 0, 0)); enq(mk(0, 0, 0));
    out_ready = 1'b1;
    pulse_start(64'h1000);
    chk("t2_id3", 64'(b_out_entry[7:0]), 3);
    chk("t2_base3", b_base, 64'h1000);
    chk("t2_depth0", 64'(b_depth), 0);
    tick();
    chk("t2_id1", 64'(b_out_entry[7:0]), 1);
    chk("t2_base1", b_base, 64'h1040);
    chk("t2_depth1", 64'(b_depth), 1);
    tick();
    chk("t2_inner_marker_valid", 64'(b_out_valid), 0);
    tick();
    chk("t2_pop_depth", 64'(b_depth), 0);
    chk("t2_id4", 64'(b_out_entry[7:0]), 4);
    chk("t2_base4", b_base, 64'h1000);
    chk("t2_v4", 64'(b_out_valid), 1);
    tick();
    chk("t2_root_marker_valid", 64'(b_out_valid), 0);
    tick();
    chk("t2_done", 64'(b_done), 1);
    chk("t2_count0", 64'(b_count), 0);
    out_ready = 1'b0;

    // 3: backpressure and wrap on the 4-deep FIFO
    do_reset();
    for (int i = 1; i <= 4; i++) enq(mk(8'(i), 0, 0));
    chk("t3_full_count", 64'(a_count), 4);
    chk("t3_full_ready", 64'(a_in_ready), 0);
    enq(mk(8'hEE, 0, 0));
    chk("t3_fifth_ignored", 64'(a_count), 4);
    pulse_start(64'h2000);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_id", 64'(a_out_entry[7:0]), 1);
      chk("t3_stall_valid", 64'(a_out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_after_deq_count", 64'(a_count), 3);
    exp_q = '{8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 10; k++) begin
      chk("t3_order", 64'(a_out_entry[7:0]), 64'(exp_q[0]));
      in_entry = mk(8'(5 + k), 0, 0);
      in_valid = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(8'(5 + k));
      chk("t3_count_stable", 64'(a_count), 3);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // 4: stack overflow with STACK_DEPTH=2
    do_reset();
    enq(mk(5, 1, 64'h10)); enq(mk(6, 1, 64'h20)); enq(mk(7, 0, 0));
    out_ready = 1'b1;
    pulse_start(64'h3000);
    chk("t4_base_root", a_base, 64'h3000);
    tick();
    chk("t4_depth1", 64'(a_depth), 1);
    chk("t4_base_child", a_base, 64'h3010);
    chk("t4_id6", 64'(a_out_entry[7:0]), 6);
    tick();
    chk("t4_err", 64'(a_err), 1);
    chk("t4_state_err", 64'(a_state), 3);
    chk("t4_valid0", 64'(a_out_valid), 0);
    chk("t4_depth_kept", 64'(a_depth), 1);
    chk("t4_count1", 64'(a_count), 1);
    pulse_start(64'h4000);
    out_ready = 1'b0;
    chk("t4_err_clear", 64'(a_err), 0);
    chk("t4_state_run", 64'(a_state), 1);
    chk("t4_depth0", 64'(a_depth), 0);
    chk("t4_id7", 64'(a_out_entry[7:0]), 7);
    chk("t4_base_new", a_base, 64'h4000);

    // 5: flush during RUN
    do_reset();
    enq(mk(3, 1, 64'h40)); enq(mk(1, 0, 0)); enq(mk(2, 0, 0)); enq(mk(9, 0, 0));
    out_ready = 1'b1;
    pulse_start(64'h1000);
    tick();
    out_ready = 1'b0;
    chk("t5_pre_count", 64'(b_count), 3);
    chk("t5_pre_depth", 64'(b_depth), 1);
    flush = 1'b1;
    in_entry = mk(8, 0, 0);
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_count0", 64'(b_count), 0);
    chk("t5_depth_kept", 64'(b_depth), 1);
    chk("t5_base_kept", b_base, 64'h1040);
    chk("t5_valid0", 64'(b_out_valid), 0);
    chk("t5_state_run", 64'(b_state), 1);
    tick();
    chk("t5_enq_dropped", 64'(b_count), 0);

    // 6: asynchronous reset mid-message
    do_reset();
    enq(mk(3, 1, 64'h40)); enq(mk(4, 1, 64'h8));
    for (int i = 1; i <= 5; i++) enq(mk(8'(i), 0, 0));
    out_ready = 1'b1;
    pulse_start(64'h1000);
    tick();
    tick();
    out_ready = 1'b0;
    chk("t6_pre_depth", 64'(b_depth), 2);
    chk("t6_pre_count", 64'(b_count), 5);
    chk("t6_pre_base", b_base, 64'h1048);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count", 64'(b_count), 0);
    chk("t6_depth", 64'(b_depth), 0);
    chk("t6_base", b_base, 64'h100);
    chk("t6_done", 64'(b_done), 0);
    chk("t6_valid", 64'(b_out_valid), 0);
    chk("t6_in_ready", 64'(b_in_ready), 1);
    chk("t6_state", 64'(b_state), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
